// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder: field-bundle input side, instruction-word output side,
// error pulses and emitted-word count. The encoder uses the slave modport, its driver the master.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_mode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             err_illegal;
  logic             err_imm;
  logic [CNT_W-1:0] emit_count;

  modport master (
    output in_valid, in_mode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, err_illegal, err_imm, emit_count
  );

  modport slave (
    input  in_valid, in_mode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, err_illegal, err_imm, emit_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction assembler: mode code + fields -> 32-bit word, queued in a DEPTH-entry FIFO.
// Optional immediate range/alignment checking is built when INSTR_ENCODER_IMM_CHECK_EN is defined.
module instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_encoder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  // True when the immediate cannot be represented exactly by the chosen format.
  function automatic logic imm_bad(input logic [3:0] mode, input logic [31:0] imm);
    logic signed [31:0] s;
    logic               bad;
    s = signed'(imm);
    case (mode)
      4'd2, 4'd3, 4'd4, 4'd10: bad = (s < -32'sd2048) || (s > 32'sd2047);
      4'd5:                    bad = (s < -32'sd4096) || (s > 32'sd4094) || imm[0];
      4'd6:                    bad = (s < -32'sd1048576) || (s > 32'sd1048574) || imm[0];
      4'd7, 4'd8:              bad = (imm[11:0] != 12'h000);
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [OW-1:0]    occ_q;
  logic             err_illegal_q;
  logic             err_imm_q;
  logic [CNT_W-1:0] emit_q;

  logic [31:0]      word_s;
  logic             legal_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             imm_bad_s;

  // Field placement per instruction format; illegal modes produce no word.
  always_comb begin
    word_s  = 32'h0000_0000;
    legal_s = 1'b1;
    case (bus.in_mode)
      4'd0: word_s = 32'h0000_0000;
      4'd1: word_s = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_R};
      4'd2: word_s = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IMM};
      4'd3: word_s = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
      4'd4: word_s = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                      bus.in_imm[4:0], OP_STORE};
      4'd5: word_s = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                      bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
      4'd6: word_s = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                      bus.in_rd, OP_JAL};
      4'd7: word_s = {bus.in_imm[31:12], bus.in_rd, OP_LUI};
      4'd8: word_s = {bus.in_imm[31:12], bus.in_rd, OP_AUIPC};
      4'd10: word_s = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OP_JALR};
      default: begin
        word_s  = 32'h0000_0000;
        legal_s = 1'b0;
      end
    endcase
  end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  assign imm_bad_s = imm_bad(bus.in_mode, bus.in_imm);
`else
  assign imm_bad_s = 1'b0;
`endif

  // in_ready looks only at registered occupancy, so a full FIFO never accepts even when popping.
  assign in_ready_s  = (occ_q != OW'(DEPTH));
  assign out_valid_s = (occ_q != OW'(0));
  assign accept_s    = bus.in_valid && in_ready_s;
  assign push_s      = accept_s && legal_s;
  assign pop_s       = out_valid_s && bus.out_ready;

  // FIFO storage, pointers, occupancy, error pulses and emitted-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
      wr_ptr_q      <= AW'(0);
      rd_ptr_q      <= AW'(0);
      occ_q         <= OW'(0);
      err_illegal_q <= 1'b0;
      err_imm_q     <= 1'b0;
      emit_q        <= CNT_W'(0);
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= word_s;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
      err_illegal_q <= accept_s && !legal_s;
      err_imm_q     <= push_s && imm_bad_s;
      if (pop_s && (emit_q != {CNT_W{1'b1}})) begin
        emit_q <= emit_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.out_instr   = out_valid_s ? mem_q[rd_ptr_q] : 32'h0000_0000;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_imm     = err_imm_q;
  assign bus.emit_count  = emit_q;

endmodule
